// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: FSM state encoding, default bus widths
// and the attribute/character field layout of a VRAM word.
package vram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_ACC,
    S_CPU_DONE,
    S_DRAW_WAIT,
    S_LOCKED
  } arb_state_t;

  localparam int VRAM_ADDR_W = 11;
  localparam int VRAM_DATA_W = 16;

  localparam int ATTR_MSB = 15;
  localparam int ATTR_LSB = 8;
  localparam int CHAR_MSB = 7;
  localparam int CHAR_LSB = 0;

endpackage

// File: rtl/vram_arbiter_frame_timer.sv
// Frame timer: free-runs 0..FRAME_DIV-1 while DRAW_EN is high and emits a
// one-cycle tick on the terminal count; parked at zero while disabled.
module frame_timer #(
  parameter int FRAME_DIV = 1000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic DRAW_EN,
  output logic tick
);

  localparam int CNT_W = $clog2(FRAME_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] frameCnt;

  assign tick = DRAW_EN && (frameCnt == LAST_CNT);

  always_ff @(posedge CLK) begin
    if (RESET || !DRAW_EN) begin
      frameCnt <= '0;
    end else if (tick) begin
      frameCnt <= '0;
    end else begin
      frameCnt <= frameCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares the single-port VRAM between CPU bus glue and the GPU,
// schedules GPU redraws from the frame timer and hands the GPU exclusive access while locked.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int FRAME_DIV    = 1000000,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DRAW_EN,
  input  logic              CPU_REQ,
  input  logic              CPU_WRITE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DATA_W,
  output logic [DATA_W-1:0] CPU_DATA_R,
  output logic              CPU_ACK,
  input  logic              GPU_ENABLE,
  input  logic              GPU_WRITE,
  input  logic [ADDR_W-1:0] GPU_ADDR,
  input  logic [DATA_W-1:0] GPU_DATA_W,
  output logic [DATA_W-1:0] GPU_DATA_R,
  input  logic              GPU_LOCK,
  input  logic              GPU_READY,
  output logic              GPU_DRAW,
  output logic              RAM_ENABLE,
  output logic              RAM_WRITE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DATA_W,
  input  logic [DATA_W-1:0] RAM_DATA_R,
  output logic              STAT_DROP
);

  // The draw-strobe cycle counts toward the timeout, so the wait state lasts LOCK_TIMEOUT-1 cycles.
  localparam int TO_W = $clog2(LOCK_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 2);

  arb_state_t        state, stateNext;
  logic              drawPending;
  logic              frameTick;
  logic              gpuDraw;
  logic              cpuAccept;
  logic [TO_W-1:0]   waitCnt;
  logic              cpuWrite;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuData;

  frame_timer #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .DRAW_EN(DRAW_EN),
    .tick   (frameTick)
  );

  always_comb begin
    stateNext = state;
    gpuDraw   = 1'b0;
    cpuAccept = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (drawPending && GPU_READY) begin
          gpuDraw   = 1'b1;
          stateNext = S_DRAW_WAIT;
        end else if (CPU_REQ && !CPU_ACK) begin
          cpuAccept = 1'b1;
          stateNext = S_CPU_ACC;
        end
      end
      S_CPU_ACC:   stateNext = S_CPU_DONE;
      S_CPU_DONE:  stateNext = S_IDLE;
      S_DRAW_WAIT: begin
        if (GPU_LOCK) begin
          stateNext = S_LOCKED;
        end else if (waitCnt == TO_LAST) begin
          stateNext = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (!GPU_LOCK) begin
          stateNext = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  assign GPU_DRAW   = gpuDraw && !RESET;
  assign GPU_DATA_R = RAM_DATA_R;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      drawPending <= 1'b0;
      STAT_DROP   <= 1'b0;
      CPU_ACK     <= 1'b0;
      CPU_DATA_R  <= '0;
      waitCnt     <= '0;
    end else begin
      state   <= stateNext;
      CPU_ACK <= (state == S_CPU_DONE);
      waitCnt <= (state == S_DRAW_WAIT) ? waitCnt + TO_W'(1) : '0;
      // A new tick wins over the strobe clearing the pending flag.
      if (frameTick) begin
        drawPending <= 1'b1;
        if (drawPending) begin
          STAT_DROP <= 1'b1;
        end
      end else if (gpuDraw) begin
        drawPending <= 1'b0;
      end
      if (state == S_CPU_DONE && !cpuWrite) begin
        CPU_DATA_R <= RAM_DATA_R;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (cpuAccept) begin
      cpuWrite <= CPU_WRITE;
      cpuAddr  <= CPU_ADDR;
      cpuData  <= CPU_DATA_W;
    end
  end

  always_comb begin
    RAM_ENABLE = 1'b0;
    RAM_WRITE  = 1'b0;
    RAM_ADDR   = '0;
    RAM_DATA_W = '0;
    if (state == S_LOCKED) begin
      RAM_ENABLE = GPU_ENABLE;
      RAM_WRITE  = GPU_WRITE;
      RAM_ADDR   = GPU_ADDR;
      RAM_DATA_W = GPU_DATA_W;
    end else if (state == S_CPU_ACC) begin
      RAM_ENABLE = 1'b1;
      RAM_WRITE  = cpuWrite;
      RAM_ADDR   = cpuAddr;
      RAM_DATA_W = cpuData;
    end
    if (RESET) begin
      RAM_ENABLE = 1'b0;
      RAM_WRITE  = 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed arbitration/timeout/drop/reset scenarios plus
// random CPU traffic checked against a shadow copy of VRAM contents.
module tb_vram_arbiter;

  localparam int FDIV = 100;
  localparam int LTO  = 64;

  logic        CLK = 1'b0;
  logic        RESET, DRAW_EN;
  logic        CPU_REQ, CPU_WRITE, CPU_ACK;
  logic [10:0] CPU_ADDR;
  logic [15:0] CPU_DATA_W, CPU_DATA_R;
  logic        GPU_ENABLE, GPU_WRITE, GPU_LOCK, GPU_READY, GPU_DRAW;
  logic [10:0] GPU_ADDR;
  logic [15:0] GPU_DATA_W, GPU_DATA_R;
  logic        RAM_ENABLE, RAM_WRITE;
  logic [10:0] RAM_ADDR;
  logic [15:0] RAM_DATA_W, RAM_DATA_R;
  logic        STAT_DROP;

  logic [15:0] mem [0:2047];
  logic [15:0] ramQ;
  int          enCount = 0;
  int          wrCount = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] shadow [int];

  always #5 CLK = ~CLK;

  vram_arbiter #(
    .ADDR_W(11), .DATA_W(16), .FRAME_DIV(FDIV), .LOCK_TIMEOUT(LTO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DRAW_EN(DRAW_EN),
    .CPU_REQ(CPU_REQ), .CPU_WRITE(CPU_WRITE), .CPU_ADDR(CPU_ADDR),
    .CPU_DATA_W(CPU_DATA_W), .CPU_DATA_R(CPU_DATA_R), .CPU_ACK(CPU_ACK),
    .GPU_ENABLE(GPU_ENABLE), .GPU_WRITE(GPU_WRITE), .GPU_ADDR(GPU_ADDR),
    .GPU_DATA_W(GPU_DATA_W), .GPU_DATA_R(GPU_DATA_R), .GPU_LOCK(GPU_LOCK),
    .GPU_READY(GPU_READY), .GPU_DRAW(GPU_DRAW),
    .RAM_ENABLE(RAM_ENABLE), .RAM_WRITE(RAM_WRITE), .RAM_ADDR(RAM_ADDR),
    .RAM_DATA_W(RAM_DATA_W), .RAM_DATA_R(RAM_DATA_R), .STAT_DROP(STAT_DROP)
  );

  // Single-port synchronous VRAM with one-cycle read latency.
  always @(posedge CLK) begin
    if (RAM_ENABLE) begin
      if (RAM_WRITE) begin
        mem[RAM_ADDR] <= RAM_DATA_W;
        wrCount <= wrCount + 1;
      end
      ramQ <= mem[RAM_ADDR];
      enCount <= enCount + 1;
    end
  end
  assign RAM_DATA_R = ramQ;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one CPU access; lat counts clock edges from the request to the ACK cycle.
  task automatic cpu_op(input logic wr, input logic [10:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat);
    CPU_REQ = 1'b1; CPU_WRITE = wr; CPU_ADDR = a; CPU_DATA_W = d;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!CPU_ACK && lat < 400);
    rd = CPU_DATA_R;
    CPU_REQ = 1'b0;
    step();
  endtask

  initial begin
    logic [15:0] rd;
    int          lat, en0, wr0, pulses, acks;
    logic        wr;
    logic [10:0] a;
    logic [15:0] d;

    RESET = 1'b1; DRAW_EN = 1'b0;
    CPU_REQ = 1'b0; CPU_WRITE = 1'b0; CPU_ADDR = '0; CPU_DATA_W = '0;
    GPU_ENABLE = 1'b0; GPU_WRITE = 1'b0; GPU_ADDR = '0; GPU_DATA_W = '0;
    GPU_LOCK = 1'b0; GPU_READY = 1'b1;
    repeat (3) step();
    chk("rst_ram_en", 32'(RAM_ENABLE), 32'd0);
    RESET = 1'b0;
    #1;
    chk("rst_ack", 32'(CPU_ACK), 32'd0);
    chk("rst_rdata", 32'(CPU_DATA_R), 32'd0);
    chk("rst_draw", 32'(GPU_DRAW), 32'd0);
    chk("rst_drop", 32'(STAT_DROP), 32'd0);
    chk("rst_ram_wr", 32'(RAM_WRITE), 32'd0);
    step();

    // CPU write then read back
    en0 = enCount; wr0 = wrCount;
    cpu_op(1'b1, 11'h123, 16'h1F41, rd, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_en_cycles", 32'(enCount - en0), 32'd1);
    chk("wr_writes", 32'(wrCount - wr0), 32'd1);
    en0 = enCount;
    cpu_op(1'b0, 11'h123, 16'h0000, rd, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", 32'(rd), 32'h1F41);
    chk("rd_en_cycles", 32'(enCount - en0), 32'd1);

    // GPU without lock is isolated from the VRAM
    GPU_ENABLE = 1'b1; GPU_WRITE = 1'b1; GPU_ADDR = 11'h123; GPU_DATA_W = 16'hDEAD;
    wr0 = wrCount; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (RAM_WRITE || RAM_ENABLE) pulses++;
    end
    chk("iso_ram_active", 32'(pulses), 32'd0);
    chk("iso_writes", 32'(wrCount - wr0), 32'd0);
    GPU_ENABLE = 1'b0; GPU_WRITE = 1'b0;
    cpu_op(1'b0, 11'h123, 16'h0000, rd, lat);
    chk("iso_rd_data", 32'(rd), 32'h1F41);

    // Random CPU traffic against the shadow memory
    for (int n = 0; n < 24; n++) begin
      a  = 11'h200 + 11'($urandom_range(0, 15));
      d  = 16'($urandom);
      wr = 1'($urandom_range(0, 1));
      if (!shadow.exists(int'(a))) wr = 1'b1;
      en0 = enCount;
      cpu_op(wr, a, d, rd, lat);
      chk("rnd_lat", 32'(lat), 32'd3);
      chk("rnd_en_cycles", 32'(enCount - en0), 32'd1);
      if (wr) shadow[int'(a)] = d;
      else    chk("rnd_rd_data", 32'(rd), 32'(shadow[int'(a)]));
      repeat ($urandom_range(0, 3)) step();
    end

    // Draw wins over a CPU request arriving with the pending draw
    DRAW_EN = 1'b1; GPU_READY = 1'b1; pulses = 0;
    for (int k = 1; k < FDIV; k++) begin
      step();
      if (GPU_DRAW) pulses++;
    end
    chk("arb_early_draw", 32'(pulses), 32'd0);
    step();
    DRAW_EN = 1'b0;
    CPU_REQ = 1'b1; CPU_WRITE = 1'b0; CPU_ADDR = 11'h050;
    #1;
    chk("arb_draw_strobe", 32'(GPU_DRAW), 32'd1);
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (CPU_ACK || RAM_ENABLE || GPU_DRAW) acks++;
    end
    chk("arb_wait_blocked", 32'(acks), 32'd0);
    GPU_LOCK = 1'b1;
    step();
    GPU_ENABLE = 1'b1; GPU_WRITE = 1'b1; GPU_ADDR = 11'h050; GPU_DATA_W = 16'hBEEF;
    #1;
    chk("lock_ram_en", 32'(RAM_ENABLE), 32'd1);
    chk("lock_ram_wr", 32'(RAM_WRITE), 32'd1);
    chk("lock_ram_addr", 32'(RAM_ADDR), 32'h050);
    chk("lock_ram_data", 32'(RAM_DATA_W), 32'hBEEF);
    step();
    GPU_WRITE = 1'b0;
    #1;
    chk("lock_ram_rd", 32'(RAM_WRITE), 32'd0);
    step();
    chk("lock_gpu_rdata", 32'(GPU_DATA_R), 32'hBEEF);
    chk("lock_cpu_ack", 32'(CPU_ACK), 32'd0);
    GPU_LOCK = 1'b0; GPU_ENABLE = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!CPU_ACK && lat < 400);
    chk("unlock_ack_lat", 32'(lat), 32'd4);
    chk("unlock_rd_data", 32'(CPU_DATA_R), 32'hBEEF);
    CPU_REQ = 1'b0;
    step();

    // Lock never arrives: draw abandoned after the timeout, CPU then served
    DRAW_EN = 1'b1;
    repeat (FDIV) step();
    #1;
    chk("to_draw_strobe", 32'(GPU_DRAW), 32'd1);
    DRAW_EN = 1'b0;
    CPU_REQ = 1'b1; CPU_WRITE = 1'b1; CPU_ADDR = 11'h060; CPU_DATA_W = 16'h1234;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!CPU_ACK && lat < 400);
    chk("to_ack_lat", 32'(lat), 32'(LTO + 3));
    CPU_REQ = 1'b0;
    step();
    cpu_op(1'b0, 11'h060, 16'h0000, rd, lat);
    chk("to_rd_data", 32'(rd), 32'h1234);

    // Two ticks with the GPU busy: sticky drop flag
    GPU_READY = 1'b0; DRAW_EN = 1'b1; pulses = 0;
    repeat (FDIV) begin
      step();
      if (GPU_DRAW) pulses++;
    end
    chk("drop_first_tick", 32'(STAT_DROP), 32'd0);
    repeat (FDIV) begin
      step();
      if (GPU_DRAW) pulses++;
    end
    chk("drop_second_tick", 32'(STAT_DROP), 32'd1);
    chk("drop_no_draw", 32'(pulses), 32'd0);
    DRAW_EN = 1'b0; GPU_READY = 1'b1;
    #1;
    chk("drop_late_draw", 32'(GPU_DRAW), 32'd1);
    repeat (LTO + 10) step();
    chk("drop_sticky", 32'(STAT_DROP), 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    #1;
    chk("drop_cleared", 32'(STAT_DROP), 32'd0);
    step();

    // Reset while the CPU access is on the VRAM bus
    CPU_REQ = 1'b1; CPU_WRITE = 1'b0; CPU_ADDR = 11'h123;
    step();
    chk("racc_ram_en", 32'(RAM_ENABLE), 32'd1);
    RESET = 1'b1;
    #1;
    chk("racc_ram_en_rst", 32'(RAM_ENABLE), 32'd0);
    step();
    RESET = 1'b0; CPU_REQ = 1'b0;
    #1;
    chk("racc_rdata", 32'(CPU_DATA_R), 32'd0);
    chk("racc_draw", 32'(GPU_DRAW), 32'd0);
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      if (CPU_ACK || RAM_ENABLE) acks++;
      step();
    end
    chk("racc_no_ack", 32'(acks), 32'd0);
    cpu_op(1'b0, 11'h123, 16'h0000, rd, lat);
    chk("racc_retry_lat", 32'(lat), 32'd3);
    chk("racc_retry_data", 32'(rd), 32'h1F41);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
